// File: rtl/puzzle_case_loader.sv
// Collects 3x3 sliding-puzzle cases from a tile stream, validates them and
// writes accepted cases into the solver's image region in shared memory.
module puzzle_case_loader #(
  parameter int IMAGE_OFFSET = 16384,
  parameter int MAX_CASES    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [3:0]  in_tile,
  output logic        in_ready,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic [5:0]  case_count,
  output logic        case_done,
  output logic        case_reject,
  output logic [1:0]  err_code,
  output logic        full
);

  typedef enum logic [1:0] {COLLECT, CHECK, WRITE, FULL} state_t;

  localparam logic [5:0] MAX_CNT = 6'(MAX_CASES);

  state_t      state_reg, state_next;
  logic [3:0]  idx_reg;
  logic [8:0]  seen_reg;
  logic        parity_reg;
  logic        range_err_reg;
  logic        dup_err_reg;
  logic [3:0]  k_reg;
  logic [5:0]  case_count_reg;
  logic        case_done_reg;
  logic        case_reject_reg;
  logic [1:0]  err_code_reg;
  logic [3:0]  tile_buf [9];

  logic        accept;
  logic [15:0] seen_ext;
  logic [15:0] upper_par;
  logic [1:0]  check_code;
  logic [9:0]  slot_base;
  logic [31:0] word_addr;

  assign accept   = in_valid && (state_reg == COLLECT);
  assign seen_ext = {7'b0, seen_reg};

  // upper_par[t] = parity of the already-seen tiles greater than t, i.e. the
  // number of inversions that tile t adds when it arrives now.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_par
      if (gi < 8) begin : g_low
        assign upper_par[gi] = ^seen_reg[8:gi+1];
      end else begin : g_high
        assign upper_par[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    check_code = 2'd0;
    if (range_err_reg)    check_code = 2'd1;
    else if (dup_err_reg) check_code = 2'd2;
    else if (parity_reg)  check_code = 2'd3;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COLLECT: if (accept && idx_reg == 4'd8) state_next = CHECK;
      CHECK:   state_next = (check_code != 2'd0) ? COLLECT : WRITE;
      WRITE: begin
        if (mem_ready && k_reg == 4'd8)
          state_next = (case_count_reg + 6'd1 == MAX_CNT) ? FULL : COLLECT;
      end
      FULL:    state_next = FULL;
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= COLLECT;
      idx_reg         <= 4'd0;
      seen_reg        <= 9'd0;
      parity_reg      <= 1'b0;
      range_err_reg   <= 1'b0;
      dup_err_reg     <= 1'b0;
      k_reg           <= 4'd0;
      case_count_reg  <= 6'd0;
      case_done_reg   <= 1'b0;
      case_reject_reg <= 1'b0;
      err_code_reg    <= 2'd0;
    end else begin
      state_reg       <= state_next;
      case_done_reg   <= 1'b0;
      case_reject_reg <= 1'b0;
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            idx_reg <= (idx_reg == 4'd8) ? 4'd0 : idx_reg + 4'd1;
            if (in_tile > 4'd8) begin
              range_err_reg <= 1'b1;
            end else begin
              if (seen_ext[in_tile]) dup_err_reg <= 1'b1;
              seen_reg <= seen_reg | (9'(1) << in_tile);
              if (in_tile != 4'd0) parity_reg <= parity_reg ^ upper_par[in_tile];
            end
          end
        end
        CHECK: begin
          idx_reg       <= 4'd0;
          seen_reg      <= 9'd0;
          parity_reg    <= 1'b0;
          range_err_reg <= 1'b0;
          dup_err_reg   <= 1'b0;
          k_reg         <= 4'd0;
          err_code_reg  <= check_code;
          if (check_code != 2'd0) case_reject_reg <= 1'b1;
        end
        WRITE: begin
          if (mem_ready) begin
            if (k_reg == 4'd8) begin
              k_reg          <= 4'd0;
              case_count_reg <= case_count_reg + 6'd1;
              case_done_reg  <= 1'b1;
            end else begin
              k_reg <= k_reg + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tile buffer holds its contents through WRITE; no reset needed.
  always_ff @(posedge clk) begin
    if (accept) tile_buf[idx_reg] <= in_tile;
  end

  assign slot_base = {4'b0, case_count_reg} * 10'd9;
  assign word_addr = 32'(IMAGE_OFFSET) + {22'b0, slot_base} + {28'b0, k_reg};

  assign in_ready    = (state_reg == COLLECT);
  assign mem_valid   = (state_reg == WRITE);
  assign mem_write   = mem_valid;
  assign mem_addr    = mem_valid ? {word_addr[29:0], 2'b00} : 32'd0;
  assign mem_wdata   = mem_valid ? {28'b0, tile_buf[k_reg]} : 32'd0;
  assign case_count  = case_count_reg;
  assign case_done   = case_done_reg;
  assign case_reject = case_reject_reg;
  assign err_code    = err_code_reg;
  assign full        = (case_count_reg == MAX_CNT);

endmodule
